// File: rtl/paramfifo_pkg.sv
// Shared FIFO definitions: pointer/count width helpers and depth derivation.
// Kept separate so the planned async FIFO variants can reuse the same sizing rules.
// FIFO_PTR_W(d) / FIFO_CNT_W(d) give pointer and occupancy widths for an entry count d.
`ifndef FIFO_DEFS_VH
`define FIFO_DEFS_VH
`define FIFO_PTR_W(d) ($clog2(d))
`define FIFO_CNT_W(d) ($clog2(d) + 1)
`endif

package paramfifo_pkg;

    // Entry count from its log2; the FIFO only supports power-of-two depths.
    function automatic int fifo_depth(input int depth_log2);
        return 1 << depth_log2;
    endfunction

    // Pointer width for a given entry count.
    function automatic int fifo_ptr_w(input int depth);
        return `FIFO_PTR_W(depth);
    endfunction

    // Occupancy/space counter width; one extra bit so the value DEPTH fits.
    function automatic int fifo_cnt_w(input int depth);
        return `FIFO_CNT_W(depth);
    endfunction

endpackage

// File: rtl/paramfifo_ram.sv
// Storage array for paramfifo: WIDTH x DEPTH, one synchronous write port, one async read port.
// Latency: write visible on rdata the cycle after the write edge; read is combinational.
// Backpressure: none; the caller qualifies we.
module paramfifo_ram #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [0:(1 << ADDR_W)-1];

    // Storage is deliberately not reset so it maps onto distributed RAM / SRLs.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/paramfifo.sv
// Parametrised synchronous FWFT FIFO, DEPTH = 2^DEPTH_LOG2 entries of WIDTH bits.
// Latency: a write is visible on dataout (empty=0) one cycle after the write edge.
// Backpressure: full/empty gate write/read; illegal ops are dropped. Sticky overflow/underflow with PARAMFIFO_ERR_FLAGS_EN.
module paramfifo
    import paramfifo_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      datain,
    input  logic                  write,
    output logic [WIDTH-1:0]      dataout,
    input  logic                  read,
    input  logic                  clear,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   space,
    output logic [DEPTH_LOG2:0]   occupied,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = fifo_depth(DEPTH_LOG2);
    localparam int PTR_W = fifo_ptr_w(DEPTH);
    localparam int CNT_W = fifo_cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             rd_ok, wr_ok, ram_we;
    logic [CNT_W-1:0] occ_nxt, spc_nxt;

    // A pop frees a slot in the same cycle, so a full FIFO can accept a write alongside a read.
    assign rd_ok  = read & ~empty;
    assign wr_ok  = write & (~full | rd_ok);
    assign ram_we = wr_ok & ~clear;

    paramfifo_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (datain),
        .raddr (rd_ptr),
        .rdata (dataout)
    );

    // Next occupancy/space; unchanged when both or neither strobe is qualified.
    always_comb begin
        occ_nxt = occupied;
        spc_nxt = space;
        if (wr_ok && !rd_ok) begin
            occ_nxt = occupied + 1'b1;
            spc_nxt = space - 1'b1;
        end else if (rd_ok && !wr_ok) begin
            occ_nxt = occupied - 1'b1;
            spc_nxt = space + 1'b1;
        end
    end

    // Pointers, counters and flags; clear overrides any read/write in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occupied <= '0;
            space    <= CNT_DEPTH;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occupied <= '0;
            space    <= CNT_DEPTH;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occupied <= occ_nxt;
            space    <= spc_nxt;
            full     <= (occ_nxt == CNT_DEPTH);
            empty    <= (occ_nxt == '0);
        end
    end

`ifdef PARAMFIFO_ERR_FLAGS_EN
    logic ovf_q, unf_q;

    // Sticky error flags: a dropped write or dropped read latches until clear or reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (clear) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (write && !wr_ok) begin
                ovf_q <= 1'b1;
            end
            if (read && !rd_ok) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_paramfifo.sv
// Self-checking bench for paramfifo (DEPTH_LOG2=4, WIDTH=8) against a queue-based reference model.
// Inputs change after the falling edge; outputs are sampled on the falling edge.
// Expected head-of-queue data is pushed on each accepted write and compared on each pop.
module tb_paramfifo;

    localparam int W  = 8;
    localparam int DL = 4;
    localparam int D  = 1 << DL;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  datain;
    logic          write, read, clear;
    logic [W-1:0]  dataout;
    logic          full, empty, overflow, underflow;
    logic [DL:0]   space, occupied;

    logic [W-1:0]  sb[$];
    logic          exp_ovf, exp_unf;
    int            errors = 0;
    int            checks = 0;

    paramfifo #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (
        .clk       (clk),
        .rst       (rst),
        .datain    (datain),
        .write     (write),
        .dataout   (dataout),
        .read      (read),
        .clear     (clear),
        .full      (full),
        .empty     (empty),
        .space     (space),
        .occupied  (occupied),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    // Compare every observable output against the model.
    task automatic check_state(input string tag);
        int n;
        n = sb.size();
        chk({tag, ".occupied"}, 32'(occupied), 32'(n));
        chk({tag, ".space"}, 32'(space), 32'(D - n));
        chk({tag, ".sum"}, 32'(space) + 32'(occupied), 32'(D));
        chk({tag, ".full"}, 32'(full), 32'(n == D));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(exp_unf));
        if (n > 0) chk({tag, ".head"}, 32'(dataout), 32'(sb[0]));
    endtask

    // One clock of stimulus; the model is updated with the pre-edge state.
    task automatic cycle(input string tag, input logic w, input logic [W-1:0] d,
                         input logic r, input logic c);
        logic rok, wok;
        write = w; datain = d; read = r; clear = c;
        rok = r && (sb.size() > 0);
        wok = w && ((sb.size() < D) || rok);
        if (rok && !c) chk({tag, ".pop"}, 32'(dataout), 32'(sb[0]));
        @(posedge clk);
        if (c) begin
            sb.delete();
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
`ifdef PARAMFIFO_ERR_FLAGS_EN
            if (w && !wok) exp_ovf = 1'b1;
            if (r && !rok) exp_unf = 1'b1;
`endif
            if (rok) void'(sb.pop_front());
            if (wok) sb.push_back(d);
        end
        @(negedge clk);
        write = 1'b0; read = 1'b0; clear = 1'b0;
        check_state(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        exp_ovf = 1'b0; exp_unf = 1'b0;
        rst = 1'b0; write = 1'b0; read = 1'b0; clear = 1'b0; datain = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check_state("reset");

        // Fill then drain in order.
        for (int i = 0; i < D; i++) cycle("fill", 1'b1, W'(i), 1'b0, 1'b0);
        for (int i = 0; i < D; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0);

        // Offset the pointers, then fill to full across the wrap point.
        for (int i = 0; i < 10; i++) cycle("pre", 1'b1, W'(8'h30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle("pre_pop", 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < D; i++) cycle("wrap", 1'b1, W'(8'hA0 + i), 1'b0, 1'b0);

        // Write at full is dropped; simultaneous read+write at full is accepted.
        cycle("wr_full", 1'b1, 8'hEE, 1'b0, 1'b0);
        cycle("rw_full", 1'b1, 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < D; i++) cycle("wrap_pop", 1'b0, '0, 1'b1, 1'b0);

        // Read+write at empty: only the write lands.
        cycle("rw_empty", 1'b1, 8'h77, 1'b1, 1'b0);
        cycle("pop77", 1'b0, '0, 1'b1, 1'b0);
        cycle("rd_empty", 1'b0, '0, 1'b1, 1'b0);

        // Clear beats a concurrent read/write and drops the error flags.
        for (int i = 0; i < 5; i++) cycle("pre_clr", 1'b1, W'(8'h60 + i), 1'b0, 1'b0);
        cycle("clear", 1'b1, 8'h99, 1'b1, 1'b1);

        // Random mix of traffic including illegal ops.
        for (int i = 0; i < 200; i++)
            cycle("rand", 1'($urandom_range(0, 1)), W'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));

        // Async reset between edges at occupied=7.
        cycle("pre_rst", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cycle("pre_rst", 1'b1, W'(8'hC0 + i), 1'b0, 1'b0);
        #2 rst = 1'b0;
        sb.delete(); exp_ovf = 1'b0; exp_unf = 1'b0;
        #1 check_state("async_rst");
        @(negedge clk);
        rst = 1'b1;
        check_state("post_rst");
        cycle("after_rst", 1'b1, 8'h42, 1'b0, 1'b0);
        cycle("after_rst_pop", 1'b0, '0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
